pwm_reg_scheduler: RTL and testbench
====================================

// Module: pwm_reg_scheduler
// PURPOSE
//  Owns the 8-bit register bank behind the I2C target and arbitrates between two users.
//  - Host port: the I2C target's single-byte reads and writes.
//  - Frame scanner: on every PWM frame tick, copies the channel duty registers into a coherent shadow set.
//  The PWM channel engines use the shadow set, so a host write never tears a frame mid-period.
// PARAMETERS
//  REGISTERS  16  Register bank depth. Address REGISTERS-1 is MODE; all others are general or duty registers.
//  CHANNELS   8   Number of duty registers, at addresses 0..CHANNELS-1. Must be <= REGISTERS-1.
// PORTS
//  clk_i           in   1           System clock; the only clock.
//  rst_i           in   1           Asynchronous, active-high reset.
//  host_req_i      in   1           Single-cycle request strobe from the I2C target.
//  host_we_i       in   1           1 = write, 0 = read; sampled with host_req_i.
//  host_addr_i     in   8           Register id; sampled with host_req_i.
//  host_wdata_i    in   8           Write data; sampled with host_req_i.
//  host_ack_o      out  1           One-cycle completion pulse.
//  host_rdata_o    out  8           Read data; valid while host_ack_o is high.
//  host_err_o      out  1           Address >= REGISTERS; valid while host_ack_o is high.
//  host_ovf_o      out  1           One-cycle pulse: a strobe was dropped because the pending slot was full.
//  frame_tick_i    in   1           One-cycle pulse at each PWM period wrap.
//  frame_miss_o    out  1           One-cycle pulse: a tick was dropped because a tick was already pending.
//  duty_o          out  CHANNELS*8  Shadow duties; channel n occupies [8n+7:8n].
//  update_o        out  1           One-cycle pulse in the cycle duty_o changes.
//  busy_o          out  1           High whenever the FSM is not in IDLE.
// BEHAVIOUR
//  Reset (async, rst_i=1): all registers, duty_o, staging, pending flags, index and outputs go to 0; FSM goes to IDLE.
//   Reset asserted mid-scan or mid-access aborts the operation; no ack or update is issued.
//  Pending slots: one host slot (we/addr/wdata latched) and one frame flag.
//   A strobe arriving in any state fills its slot.
//   A strobe arriving while its slot is already full is dropped and pulses host_ovf_o / frame_miss_o next cycle.
//   A slot may be consumed and refilled in the same cycle.
//  FSM states: IDLE, HOST, SCAN, DONE.
//   IDLE -> HOST  if the host slot is full (host has priority over the frame flag).
//   IDLE -> SCAN  else if the frame flag is set and MODE[0] (SLEEP) = 0; clears the flag, sets idx=0.
//   IDLE, frame flag set and SLEEP=1: flag cleared, no scan, duty_o holds.
//   HOST: performs the access and clears the slot; pulses host_ack_o; -> IDLE.
//   SCAN: staging[idx] <= reg[idx]; idx++; after idx=CHANNELS-1 -> DONE.
//   DONE: duty_o <= staging (all channels at once); update_o=1; -> IDLE.
//  Latency:
//   Uncontended strobe at cycle t: HOST at t+1, host_ack_o at t+2.
//   Uncontended tick at cycle t: update_o and new duty_o at t+CHANNELS+2.
//  Coherency: the host is never served during SCAN/DONE, so a host write lands either entirely before or after a snapshot.
//  Access rules:
//   Write with addr >= REGISTERS: ignored, host_err_o=1.
//   Read with addr >= REGISTERS: returns 8'h00, host_err_o=1.
//   Write to MODE takes effect at the next IDLE decision.
//  Simultaneous host strobe and tick in IDLE: HOST first, then SCAN.
//   Worst-case host wait is CHANNELS+3 cycles, negligible against SCL.
//  Width rules: idx is $clog2(CHANNELS) bits with no wrap past CHANNELS-1; addresses compare as 8-bit unsigned.
// TESTING
//  1. Write 0x5A to addr 3 at t, read addr 3 at t+4
//     -> ack at t+2 and t+6; rdata=0x5A, err=0; all other registers 0.
//  2. Write addr 0..7 = 0x10..0x17, then tick
//     -> update_o exactly 10 cycles after tick; duty_o = {0x17,...,0x10}; update_o 1 cycle wide.
//  3. Tick, then host write 0xFF to addr 0 while SCAN is at idx=2
//     -> write acked only after update_o; duty_o[7:0]=old; next tick yields 0xFF.
//  4. Write addr 20, read addr 20
//     -> both ack with err=1, rdata=0x00; bank unchanged.
//  5. Set MODE=0x01, tick; two ticks during a scan; two host strobes while busy
//     -> no update while SLEEP=1; frame_miss_o once; host_ovf_o once.
//  6. Assert rst_i mid-SCAN
//     -> duty_o=0, no update_o, busy_o=0 immediately; a post-reset read of addr 0 returns 0x00.

Source files
------------

// File: rtl/pwm_reg_scheduler_if.sv
// ---------------------------------------------------------------------------
// pwm_reg_scheduler_if
//   Single-byte host access bus between the I2C target (master side) and the
//   PWM register scheduler (slave side).
//
//   host_req_i    master->slave  one-cycle request strobe
//   host_we_i     master->slave  1 = write, 0 = read, sampled with the strobe
//   host_addr_i   master->slave  register id, sampled with the strobe
//   host_wdata_i  master->slave  write data, sampled with the strobe
//   host_ack_o    slave->master  one-cycle completion pulse
//   host_rdata_o  slave->master  read data, valid while host_ack_o is high
//   host_err_o    slave->master  address out of range, valid with host_ack_o
//   host_ovf_o    slave->master  one-cycle pulse: a strobe was dropped
// ---------------------------------------------------------------------------
interface pwm_reg_scheduler_if;
    logic       host_req_i;
    logic       host_we_i;
    logic [7:0] host_addr_i;
    logic [7:0] host_wdata_i;
    logic       host_ack_o;
    logic [7:0] host_rdata_o;
    logic       host_err_o;
    logic       host_ovf_o;

    modport master (
        output host_req_i,
        output host_we_i,
        output host_addr_i,
        output host_wdata_i,
        input  host_ack_o,
        input  host_rdata_o,
        input  host_err_o,
        input  host_ovf_o
    );

    modport slave (
        input  host_req_i,
        input  host_we_i,
        input  host_addr_i,
        input  host_wdata_i,
        output host_ack_o,
        output host_rdata_o,
        output host_err_o,
        output host_ovf_o
    );
endinterface : pwm_reg_scheduler_if

// File: rtl/pwm_reg_scheduler.sv
// ---------------------------------------------------------------------------
// pwm_reg_scheduler
//   Owns the 8-bit register bank behind the I2C target and arbitrates between
//   host single-byte accesses and the per-frame duty snapshot.  On every PWM
//   frame tick the duty registers (addresses 0..CHANNELS-1) are copied one
//   per cycle into a staging set and then published to duty_o in a single
//   cycle, so the PWM engines never see a half-updated frame.  The host is
//   only served from IDLE, never while a snapshot is in flight.
//   Address REGISTERS-1 is MODE; bit 0 (SLEEP) suppresses snapshots.
//
// Ports
//   clk_i         system clock
//   rst_i         asynchronous active-high reset
//   host_bus      host access bus (slave modport of pwm_reg_scheduler_if)
//   frame_tick_i  one-cycle pulse at each PWM period wrap
//   frame_miss_o  one-cycle pulse: a tick was dropped (one already pending)
//   duty_o        shadow duties, channel n in [8n+7:8n]
//   update_o      one-cycle pulse in the cycle duty_o changes
//   busy_o        high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module pwm_reg_scheduler #(
    parameter int REGISTERS = 16,
    parameter int CHANNELS  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    pwm_reg_scheduler_if.slave      host_bus,
    input  logic                    frame_tick_i,
    output logic                    frame_miss_o,
    output logic [CHANNELS*8-1:0]   duty_o,
    output logic                    update_o,
    output logic                    busy_o
);

    localparam int ADDR_W    = (REGISTERS > 1) ? $clog2(REGISTERS) : 1;
    localparam int IDX_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int MODE_ADDR = REGISTERS - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOST = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_n;

    logic [7:0]       regs_q    [REGISTERS];
    logic [7:0]       staging_q [CHANNELS];
    logic [IDX_W-1:0] idx_q;

    // Pending host slot
    logic             host_full_q;
    logic             host_we_q;
    logic [7:0]       host_addr_q;
    logic [7:0]       host_wdata_q;

    // Pending frame flag
    logic             frame_flag_q;

    logic             host_avail;
    logic             frame_avail;
    logic             sleep;
    logic             host_take;
    logic             frame_take;
    logic             scan_start;
    logic             scan_last;
    logic             addr_ok;

    // The IDLE decision looks at the incoming strobes as well as the slots,
    // so an uncontended request is decided in the same cycle it arrives.
    assign host_avail  = host_full_q | host_bus.host_req_i;
    assign frame_avail = frame_flag_q | frame_tick_i;
    assign sleep       = regs_q[MODE_ADDR][0];
    assign host_take   = (state_q == HOST);
    assign scan_last   = (idx_q == IDX_W'(CHANNELS - 1));
    assign addr_ok     = (int'(host_addr_q) < REGISTERS);
    assign busy_o      = (state_q != IDLE);

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state; frame_take marks the cycle the frame request is retired
    // (either starting a scan or being discarded because SLEEP is set).
    // -----------------------------------------------------------------------
    always_comb begin
        state_n    = state_q;
        frame_take = 1'b0;
        scan_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (host_avail) begin
                    state_n = HOST;
                end else if (frame_avail) begin
                    frame_take = 1'b1;
                    if (!sleep) begin
                        state_n    = SCAN;
                        scan_start = 1'b1;
                    end
                end
            end
            HOST: state_n = IDLE;
            SCAN: begin
                if (scan_last) begin
                    state_n = DONE;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Pending slots and drop indications.  The host slot is consumed in HOST,
    // and a strobe arriving in that same cycle refills it.  The frame flag is
    // retired in IDLE; if the flag was empty the incoming tick itself is the
    // one retired, otherwise the incoming tick refills the flag.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            host_full_q         <= 1'b0;
            host_we_q           <= 1'b0;
            host_addr_q         <= 8'h00;
            host_wdata_q        <= 8'h00;
            host_bus.host_ovf_o <= 1'b0;
            frame_flag_q        <= 1'b0;
            frame_miss_o        <= 1'b0;
        end else begin
            if (host_bus.host_req_i && (!host_full_q || host_take)) begin
                host_full_q  <= 1'b1;
                host_we_q    <= host_bus.host_we_i;
                host_addr_q  <= host_bus.host_addr_i;
                host_wdata_q <= host_bus.host_wdata_i;
            end else if (host_take) begin
                host_full_q  <= 1'b0;
            end
            host_bus.host_ovf_o <= host_bus.host_req_i && host_full_q && !host_take;

            if (frame_take) begin
                frame_flag_q <= frame_flag_q && frame_tick_i;
            end else begin
                frame_flag_q <= frame_flag_q || frame_tick_i;
            end
            frame_miss_o <= frame_tick_i && frame_flag_q && !frame_take;
        end
    end

    // -----------------------------------------------------------------------
    // Register bank: written only from HOST, out-of-range writes ignored.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < REGISTERS; r++) begin
                regs_q[r] <= 8'h00;
            end
        end else if (host_take && host_we_q && addr_ok) begin
            regs_q[host_addr_q[ADDR_W-1:0]] <= host_wdata_q;
        end
    end

    // -----------------------------------------------------------------------
    // Host response, registered so it appears the cycle after HOST.
    // Read data is zero for errors and writes.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            host_bus.host_ack_o   <= 1'b0;
            host_bus.host_rdata_o <= 8'h00;
            host_bus.host_err_o   <= 1'b0;
        end else begin
            host_bus.host_ack_o   <= host_take;
            host_bus.host_rdata_o <= 8'h00;
            host_bus.host_err_o   <= 1'b0;
            if (host_take) begin
                host_bus.host_err_o <= !addr_ok;
                if (addr_ok && !host_we_q) begin
                    host_bus.host_rdata_o <= regs_q[host_addr_q[ADDR_W-1:0]];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Snapshot: one duty register per SCAN cycle into staging, then DONE
    // publishes every channel at once together with update_o.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q    <= '0;
            update_o <= 1'b0;
            duty_o   <= '0;
            for (int n = 0; n < CHANNELS; n++) begin
                staging_q[n] <= 8'h00;
            end
        end else begin
            if (scan_start) begin
                idx_q <= '0;
            end else if (state_q == SCAN && !scan_last) begin
                idx_q <= idx_q + 1'b1;
            end

            if (state_q == SCAN) begin
                staging_q[idx_q] <= regs_q[ADDR_W'(idx_q)];
            end

            update_o <= (state_q == DONE);
            if (state_q == DONE) begin
                for (int n = 0; n < CHANNELS; n++) begin
                    duty_o[8*n +: 8] <= staging_q[n];
                end
            end
        end
    end

endmodule : pwm_reg_scheduler

// File: tb/tb_pwm_reg_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pwm_reg_scheduler
//   Directed scenarios with literal expectations followed by randomized
//   traffic.  A timeline model (job start cycle + fixed job duration, output
//   events scheduled at absolute cycle numbers) predicts every output on
//   every cycle.
// ---------------------------------------------------------------------------
module tb_pwm_reg_scheduler;

    localparam int REGISTERS = 16;
    localparam int CHANNELS  = 8;
    localparam int DW        = CHANNELS * 8;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          frame_tick_i = 1'b0;
    logic          frame_miss_o;
    logic [DW-1:0] duty_o;
    logic          update_o;
    logic          busy_o;

    pwm_reg_scheduler_if hif ();

    pwm_reg_scheduler #(
        .REGISTERS (REGISTERS),
        .CHANNELS  (CHANNELS)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .host_bus     (hif),
        .frame_tick_i (frame_tick_i),
        .frame_miss_o (frame_miss_o),
        .duty_o       (duty_o),
        .update_o     (update_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Timeline model
    // -----------------------------------------------------------------------
    int            cyc = 0;
    int            free_at;      // first cycle the scheduler is back in IDLE
    int            ack_cyc, upd_cyc, cons_cyc, ovf_cyc, miss_cyc;
    logic [7:0]    m_regs [REGISTERS];
    logic [DW-1:0] m_duty, upd_duty;
    bit            m_full, m_we, m_flag;
    logic [7:0]    m_addr, m_wd;
    bit            ack_we, ack_err;
    logic [7:0]    ack_rd;

    task automatic model_reset();
        for (int r = 0; r < REGISTERS; r++) m_regs[r] = 8'h00;
        m_duty = '0; upd_duty = '0;
        m_full = 0; m_we = 0; m_flag = 0; m_addr = 0; m_wd = 0;
        free_at = 0;
        ack_cyc = -100; upd_cyc = -100; cons_cyc = -100; ovf_cyc = -100; miss_cyc = -100;
        ack_we = 0; ack_err = 0; ack_rd = 0;
    endtask

    task automatic model_step();
        bit idle, consuming, host_went;
        idle      = (cyc >= free_at);
        consuming = (cons_cyc == cyc);
        host_went = 0;
        // Host strobe arrival
        if (hif.host_req_i) begin
            if (m_full && !consuming) ovf_cyc = cyc + 1;
            else begin
                m_full = 1; m_we = hif.host_we_i; m_addr = hif.host_addr_i; m_wd = hif.host_wdata_i;
            end
        end else if (consuming) begin
            m_full = 0;
        end
        // Host job: executes next cycle, answered the cycle after
        if (idle && m_full) begin
            host_went = 1;
            ack_we = m_we;
            if (m_addr < REGISTERS) begin
                ack_err = 0;
                ack_rd  = m_regs[m_addr[3:0]];
                if (m_we) m_regs[m_addr[3:0]] = m_wd;
            end else begin
                ack_err = 1;
                ack_rd  = 8'h00;
            end
            ack_cyc  = cyc + 2;
            cons_cyc = cyc + 1;
            free_at  = cyc + 2;
        end
        // Frame job: CHANNELS copy cycles plus a publish cycle
        if (idle && !host_went && (m_flag || frame_tick_i)) begin
            if (!m_regs[REGISTERS-1][0]) begin
                for (int n = 0; n < CHANNELS; n++) upd_duty[8*n +: 8] = m_regs[n];
                upd_cyc = cyc + CHANNELS + 2;
                free_at = cyc + CHANNELS + 2;
            end
            m_flag = m_flag && frame_tick_i;
        end else begin
            if (frame_tick_i && m_flag) miss_cyc = cyc + 1;
            m_flag = m_flag || frame_tick_i;
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_i) begin
            model_reset();
            check("rst_busy",   64'(busy_o),         64'd0);
            check("rst_duty",   64'(duty_o),         64'd0);
            check("rst_update", 64'(update_o),       64'd0);
            check("rst_ack",    64'(hif.host_ack_o), 64'd0);
        end else begin
            if (upd_cyc == cyc) m_duty = upd_duty;
            check("update",  64'(update_o),         64'(upd_cyc == cyc));
            check("duty",    64'(duty_o),           64'(m_duty));
            check("ack",     64'(hif.host_ack_o),   64'(ack_cyc == cyc));
            if (ack_cyc == cyc) begin
                check("err", 64'(hif.host_err_o), 64'(ack_err));
                if (!ack_we) check("rdata", 64'(hif.host_rdata_o), 64'(ack_rd));
            end
            check("ovf",     64'(hif.host_ovf_o),   64'(ovf_cyc == cyc));
            check("miss",    64'(frame_miss_o),     64'(miss_cyc == cyc));
            check("busy",    64'(busy_o),           64'(cyc < free_at));
            model_step();
        end
        cyc++;
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers: each step() owns one clock cycle of inputs.
    // -----------------------------------------------------------------------
    task automatic step(input logic req, input logic we, input logic [7:0] addr,
                        input logic [7:0] wd, input logic tick);
        @(posedge clk_i); #1;
        hif.host_req_i   = req;
        hif.host_we_i    = we;
        hif.host_addr_i  = addr;
        hif.host_wdata_i = wd;
        frame_tick_i     = tick;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 8'h00, 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        hif.host_req_i = 0; frame_tick_i = 0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    int n_miss, n_ovf;

    initial begin
        hif.host_req_i   = 0;
        hif.host_we_i    = 0;
        hif.host_addr_i  = 0;
        hif.host_wdata_i = 0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        idle(2);

        // 1: write 0x5A to 3, read it back
        step(1, 1, 8'd3, 8'h5A, 0);
        step(0, 0, 0, 0, 0); @(negedge clk_i);
        check("t1_noack_t1", 64'(hif.host_ack_o), 64'd0);
        check("t1_busy_t1",  64'(busy_o),         64'd1);
        step(0, 0, 0, 0, 0); @(negedge clk_i);
        check("t1_wack", 64'(hif.host_ack_o), 64'd1);
        check("t1_werr", 64'(hif.host_err_o), 64'd0);
        idle(1);
        step(1, 0, 8'd3, 8'h00, 0);
        idle(1);
        step(0, 0, 0, 0, 0); @(negedge clk_i);
        check("t1_rack",   64'(hif.host_ack_o),   64'd1);
        check("t1_rdata",  64'(hif.host_rdata_o), 64'h5A);
        check("t1_rerr",   64'(hif.host_err_o),   64'd0);
        idle(2);

        // 2: load 0x10..0x17, tick, publish exactly 10 cycles later
        for (int i = 0; i < CHANNELS; i++) begin
            step(1, 1, 8'(i), 8'(8'h10 + i), 0);
            idle(1);
        end
        idle(3);
        step(0, 0, 0, 0, 1);
        for (int k = 1; k <= 11; k++) begin
            step(0, 0, 0, 0, 0); @(negedge clk_i);
            check("t2_update", 64'(update_o), 64'(k == 10));
            if (k == 10) check("t2_duty", 64'(duty_o), 64'h1716151413121110);
        end
        idle(2);

        // 3: host write during SCAN idx=2 waits for the snapshot
        step(0, 0, 0, 0, 1);
        idle(2);
        step(1, 1, 8'd0, 8'hFF, 0);
        for (int k = 4; k <= 13; k++) begin
            step(0, 0, 0, 0, 0); @(negedge clk_i);
            check("t3_ack", 64'(hif.host_ack_o), 64'(k == 12));
            if (k == 10) check("t3_duty0_old", 64'(duty_o[7:0]), 64'h10);
        end
        step(0, 0, 0, 0, 1);
        for (int k = 1; k <= 10; k++) begin
            step(0, 0, 0, 0, 0); @(negedge clk_i);
            if (k == 10) check("t3_duty0_new", 64'(duty_o[7:0]), 64'hFF);
        end
        idle(2);

        // 4: out-of-range write and read
        step(1, 1, 8'd20, 8'hAA, 0);
        idle(1);
        step(0, 0, 0, 0, 0); @(negedge clk_i);
        check("t4_werr", 64'(hif.host_err_o), 64'd1);
        step(1, 0, 8'd20, 8'h00, 0);
        idle(1);
        step(0, 0, 0, 0, 0); @(negedge clk_i);
        check("t4_rerr",   64'(hif.host_err_o),   64'd1);
        check("t4_rdata",  64'(hif.host_rdata_o), 64'h00);
        step(1, 0, 8'd4, 8'h00, 0);
        idle(1);
        step(0, 0, 0, 0, 0); @(negedge clk_i);
        check("t4_bank", 64'(hif.host_rdata_o), 64'h14);
        idle(2);

        // 5: SLEEP suppresses scans; drops while busy are flagged once each
        step(1, 1, 8'd15, 8'h01, 0);
        idle(2);
        step(0, 0, 0, 0, 1);
        n_miss = 0;
        for (int k = 1; k <= 12; k++) begin
            step(0, 0, 0, 0, 0); @(negedge clk_i);
            if (update_o) n_miss++;
        end
        check("t5_sleep_updates", 64'(n_miss), 64'd0);
        step(1, 1, 8'd15, 8'h00, 0);
        idle(2);
        step(0, 0, 0, 0, 1);
        n_miss = 0; n_ovf = 0;
        for (int k = 1; k <= 25; k++) begin
            step((k == 4) || (k == 6), 0, 8'd1, 8'h00, (k == 3) || (k == 5));
            @(negedge clk_i);
            if (frame_miss_o)    n_miss++;
            if (hif.host_ovf_o)  n_ovf++;
        end
        check("t5_miss_count", 64'(n_miss), 64'd1);
        check("t5_ovf_count",  64'(n_ovf),  64'd1);
        idle(2);

        // 6: reset mid-scan
        step(0, 0, 0, 0, 1);
        idle(3);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        check("t6_busy",   64'(busy_o),   64'd0);
        check("t6_duty",   64'(duty_o),   64'd0);
        check("t6_update", 64'(update_o), 64'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        step(1, 0, 8'd0, 8'h00, 0);
        idle(1);
        step(0, 0, 0, 0, 0); @(negedge clk_i);
        check("t6_ack",   64'(hif.host_ack_o),   64'd1);
        check("t6_rdata", 64'(hif.host_rdata_o), 64'h00);
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                pulse_reset();
            end else begin
                logic       r, w, t;
                logic [7:0] a, d;
                r = ($urandom_range(0, 99) < 30);
                w = $urandom_range(0, 1);
                a = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 19));
                d = 8'($urandom);
                if (a == 8'd15) d[0] = ($urandom_range(0, 3) == 0);
                t = ($urandom_range(0, 99) < 8);
                step(r, w, a, d, t);
            end
        end
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_pwm_reg_scheduler
